// File: rtl/l4_pkg.sv
// Shared definitions for the l4 frame driver: FSM state encoding and the
// default frame length.
package l4_pkg;

  localparam int L4_FRAME_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CLR   = 2'd3
  } state_e;

endpackage

// File: rtl/l4_shreg.sv
// Left-shift register with parallel load and serial-in LSB.
// Load has priority over shift. W must be at least 2.
module l4_shreg #(
  parameter int W = 20
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Parallel load, else shift left taking i_sin into bit 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], i_sin};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/l4_frame_driver.sv
// Frame driver for the l4part1 serial sequence detector.
// Shifts a parallel word MSB-first onto X, captures the detector's Z one
// cycle behind each bit, and returns the assembled response word.
// Optional feature: define SER_GAP_EN to insert a one-cycle detector clear
// (DET_CLR) between frames; undefined, DET_CLR is tied low.
//
// state    | meaning
// ST_IDLE  | ready for a new word
// ST_SHIFT | driving frame bits on X
// ST_FLUSH | one dead cycle while the last Z is captured
// ST_CLR   | one-cycle detector clear (SER_GAP_EN only)
module l4_frame_driver
  import l4_pkg::*;
#(
  parameter int WIDTH = L4_FRAME_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] LD_DATA,
  input  logic             LD_VALID,
  output logic             LD_READY,
  output logic             X,
  output logic             X_VALID,
  input  logic             Z,
  output logic             DET_CLR,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VALID,
  output logic [1:0]       STATE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cap_cnt;
  logic             r_x_valid;
  logic             r_cap_en;
  logic [WIDTH-1:0] r_res;
  logic             r_res_valid;
  logic [WIDTH-1:0] w_tx_q;
  logic [WIDTH-1:0] w_cap_q;
  logic             w_load;
  logic             w_shift;
  logic             w_unused;

  assign w_load  = LD_VALID && (r_state == ST_IDLE);
  assign w_shift = (r_state == ST_SHIFT);

  // Next-state decode; the frame ends after WIDTH shift edges.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (LD_VALID) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST) w_state_nxt = ST_FLUSH;
`ifdef SER_GAP_EN
      ST_FLUSH: w_state_nxt = ST_CLR;
`else
      ST_FLUSH: w_state_nxt = ST_IDLE;
`endif
      ST_CLR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Transmit bit counter: cleared on load, counts shift edges.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         r_cnt <= '0;
    else if (w_load)  r_cnt <= '0;
    else if (w_shift) r_cnt <= r_cnt + CNT_W'(1);
  end

  // X_VALID registered from next state; capture enable trails it by one cycle
  // to match the detector's register stage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_x_valid <= 1'b0;
      r_cap_en  <= 1'b0;
    end else begin
      r_x_valid <= (w_state_nxt == ST_SHIFT);
      r_cap_en  <= r_x_valid;
    end
  end

  // Capture counter and result latch; RES only updates on a full frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cap_cnt   <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (r_cap_en) begin
        if (r_cap_cnt == LAST) begin
          r_cap_cnt   <= '0;
          r_res       <= {w_cap_q[WIDTH-2:0], Z};
          r_res_valid <= 1'b1;
        end else begin
          r_cap_cnt <= r_cap_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Transmit register shifts in zeros, so X is 0 once the frame is out.
  l4_shreg #(.W(WIDTH)) u_tx (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_load),
    .i_data  (LD_DATA),
    .i_shift (w_shift),
    .i_sin   (1'b0),
    .o_q     (w_tx_q)
  );

  l4_shreg #(.W(WIDTH)) u_cap (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (1'b0),
    .i_data  ({WIDTH{1'b0}}),
    .i_shift (r_cap_en),
    .i_sin   (Z),
    .o_q     (w_cap_q)
  );

  // Only the transmit MSB and the capture low bits leave the shift chains.
  assign w_unused = ^{w_tx_q[WIDTH-2:0], w_cap_q[WIDTH-1]};

  assign X         = w_tx_q[WIDTH-1];
  assign X_VALID   = r_x_valid;
  assign LD_READY  = (r_state == ST_IDLE);
  assign RES       = r_res;
  assign RES_VALID = r_res_valid;
  assign STATE     = r_state;
`ifdef SER_GAP_EN
  assign DET_CLR   = (r_state == ST_CLR);
`else
  assign DET_CLR   = 1'b0;
`endif

endmodule
